// File: rtl/crc_ser_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the CRC result serializer.
package crc_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    function automatic int nbytes(input int dw, input int bw);
        return (dw + bw - 1) / bw;
    endfunction

    function automatic int padw(input int dw, input int bw);
        return nbytes(dw, bw) * bw - dw;
    endfunction

    localparam int DEF_DATA_W = 60;
    localparam int DEF_BYTE_W = 8;
    localparam int NBYTES     = nbytes(DEF_DATA_W, DEF_BYTE_W);
    localparam int PADW       = padw(DEF_DATA_W, DEF_BYTE_W);

endpackage

// File: rtl/crc_ser_fifo.sv
// Synchronous FIFO holding result words; push and pop may coincide, even when full.
module crc_ser_fifo
    import crc_ser_pkg::*;
#(
    parameter int DW    = 60,
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DW-1:0]           wdata_i,
    output logic [DW-1:0]           rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   level_o
);
    localparam int AW = clog2(DEPTH);

    logic [DW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [AW:0]    level_q, level_d;

    always_comb begin
        level_d = level_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Storage is not reset; the level/pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/crc_result_serializer.sv
// Buffers CRC result pulses and streams each word MSB-first as bytes over valid/ready.
// Optional even-parity output enabled by defining CRC_SER_PARITY_EN.
module crc_result_serializer
    import crc_ser_pkg::*;
#(
    parameter int pDATA_WIDTH = 60,
    parameter int pBYTE_W     = 8,
    parameter int pFIFO_DEPTH = 4
) (
    input  logic                          clk_3,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [pDATA_WIDTH-1:0]        in_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [pBYTE_W-1:0]            tx_data,
    output logic                          tx_last,
    output logic [clog2(pFIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
`ifdef CRC_SER_PARITY_EN
    ,
    output logic                          tx_parity
`endif
);
    localparam int NB  = nbytes(pDATA_WIDTH, pBYTE_W);
    localparam int PW  = padw(pDATA_WIDTH, pBYTE_W);
    localparam int SHW = NB * pBYTE_W;
    localparam int CW  = clog2(NB + 1);

    ser_state_e              state_q, state_d;
    logic [SHW-1:0]          shift_q, shift_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    last_q, last_d;
    logic                    ovf_q, ovf_d;

    logic                    push, pop, full, empty;
    logic [pDATA_WIDTH-1:0]  rd_data;
    logic [SHW-1:0]          rd_pad;
    logic                    at_last;

    crc_ser_fifo #(
        .DW    (pDATA_WIDTH),
        .DEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_3),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_data),
        .rdata_o (rd_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    assign rd_pad  = SHW'(rd_data) << PW;
    assign at_last = (cnt_q == CW'(NB - 1));

    always_ff @(posedge clk_3) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = rd_pad;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (at_last) begin
                        cnt_d = '0;
                        // Reload straight from the FIFO so consecutive words have no bubble.
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = rd_pad;
                        end else begin
                            shift_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = shift_q << pBYTE_W;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        push   = in_valid && (!full || pop);
        ovf_d  = ovf_q || (in_valid && full && !pop);
        last_d = (state_d == SEND) && (cnt_d == CW'(NB - 1));
    end

    always_ff @(posedge clk_3) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx_valid = (state_q == SEND);
    assign tx_data  = shift_q[SHW-1 -: pBYTE_W];
    assign tx_last  = last_q;
    assign overflow = ovf_q;
`ifdef CRC_SER_PARITY_EN
    assign tx_parity = ^tx_data;
`endif

endmodule

// File: tb/tb_crc_result_serializer.sv
// Directed self-checking bench for crc_result_serializer (default 60-bit word, 8-bit bytes, depth 4).
module tb_crc_result_serializer;
    logic        clk_3 = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [59:0] in_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic [2:0]  fifo_level;
    logic        overflow;
`ifdef CRC_SER_PARITY_EN
    logic        tx_parity;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    crc_result_serializer dut (
        .clk_3      (clk_3),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef CRC_SER_PARITY_EN
        ,
        .tx_parity  (tx_parity)
`endif
    );

    always #5 clk_3 = ~clk_3;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_3);
        #1;
    endtask

    task automatic pulse(input logic [59:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    // Receive nb bytes of word w; stall inserts a ready=0 cycle before each handshake,
    // strict demands tx_valid without any waiting.
    task automatic recv_word(input logic [59:0] w, input int nb, input bit stall, input bit strict);
        logic [63:0] pad;
        logic [7:0]  eb;
        int          t;
        pad = {w, 4'h0};
        for (int k = 0; k < nb; k++) begin
            eb = pad[63-8*k -: 8];
            t  = 0;
            if (!strict) begin
                while (!tx_valid && t < 40) begin
                    tick();
                    t++;
                end
            end
            chk("tx_valid", {63'd0, tx_valid}, 64'd1);
            chk("tx_data", {56'd0, tx_data}, {56'd0, eb});
            chk("tx_last", {63'd0, tx_last}, {63'd0, (k == 7)});
`ifdef CRC_SER_PARITY_EN
            chk("tx_parity", {63'd0, tx_parity}, {63'd0, ^eb});
`endif
            if (stall) begin
                tx_ready = 1'b0;
                tick();
                chk("hold_valid", {63'd0, tx_valid}, 64'd1);
                chk("hold_data", {56'd0, tx_data}, {56'd0, eb});
                chk("hold_last", {63'd0, tx_last}, {63'd0, (k == 7)});
            end
            tx_ready = 1'b1;
            tick();
        end
        tx_ready = 1'b0;
    endtask

    logic [59:0] words [6];
    logic [63:0] exp_bytes;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tx_ready = 1'b0;
        words[0] = 60'h0123456789ABCDE;
        words[1] = 60'hFEDCBA987654321;
        words[2] = 60'h111111111111111;
        words[3] = 60'h2AAAAAAAAAAAAA5;
        words[4] = 60'h0F0F0F0F0F0F0F0;
        words[5] = 60'h333333333333333;
        exp_bytes = 64'h0123456789ABCDE0;

        // 1: reset with in_valid pulses must not push anything
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            tick();
            chk("rst_valid", {63'd0, tx_valid}, 64'd0);
            chk("rst_data", {56'd0, tx_data}, 64'd0);
            chk("rst_last", {63'd0, tx_last}, 64'd0);
            chk("rst_level", {61'd0, fifo_level}, 64'd0);
            chk("rst_ovf", {63'd0, overflow}, 64'd0);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("post_rst_valid", {63'd0, tx_valid}, 64'd0);
        chk("post_rst_level", {61'd0, fifo_level}, 64'd0);

        // 2: single word, latency 2, hand-computed byte sequence
        tx_ready = 1'b1;
        pulse(words[0]);
        chk("lat1_valid", {63'd0, tx_valid}, 64'd0);
        chk("lat1_level", {61'd0, fifo_level}, 64'd1);
        tick();
        chk("lat2_valid", {63'd0, tx_valid}, 64'd1);
        chk("lat2_level", {61'd0, fifo_level}, 64'd0);
        for (int k = 0; k < 8; k++) begin
            chk("w0_valid", {63'd0, tx_valid}, 64'd1);
            chk("w0_byte", {56'd0, tx_data}, {56'd0, exp_bytes[63-8*k -: 8]});
            chk("w0_last", {63'd0, tx_last}, {63'd0, (k == 7)});
            tick();
        end
        tx_ready = 1'b0;
        chk("w0_idle", {63'd0, tx_valid}, 64'd0);

        // 3: back-pressure, every byte stalled one cycle
        pulse(words[1]);
        recv_word(words[1], 8, 1'b1, 1'b0);
        chk("bp_idle", {63'd0, tx_valid}, 64'd0);

        // 4: overflow: 1 in shift reg + 4 stored, 6th dropped
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            tick();
            if (i == 4) begin
                chk("ovf_level4", {61'd0, fifo_level}, 64'd4);
                chk("ovf_not_yet", {63'd0, overflow}, 64'd0);
            end
        end
        in_valid = 1'b0;
        chk("ovf_level_full", {61'd0, fifo_level}, 64'd4);
        chk("ovf_sticky", {63'd0, overflow}, 64'd1);
        for (int i = 0; i < 5; i++) recv_word(words[i], 8, 1'b0, 1'b0);
        tick();
        chk("ovf_drained_valid", {63'd0, tx_valid}, 64'd0);
        chk("ovf_drained_level", {61'd0, fifo_level}, 64'd0);
        chk("ovf_still", {63'd0, overflow}, 64'd1);

        // 5: back-to-back words, no bubble between E0 and next first byte
        pulse(words[0]);
        pulse(words[3]);
        recv_word(words[0], 8, 1'b0, 1'b0);
        tx_ready = 1'b1;
        recv_word(words[3], 8, 1'b0, 1'b1);
        chk("b2b_idle", {63'd0, tx_valid}, 64'd0);

        // 6: reset mid-word after 3 bytes; queued word flushed, new word restarts
        pulse(words[4]);
        pulse(words[5]);
        recv_word(words[4], 3, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {63'd0, tx_valid}, 64'd0);
        chk("mid_rst_level", {61'd0, fifo_level}, 64'd0);
        chk("mid_rst_data", {56'd0, tx_data}, 64'd0);
        chk("mid_rst_ovf", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("flushed_valid", {63'd0, tx_valid}, 64'd0);
        pulse(words[2]);
        recv_word(words[2], 8, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
